// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// The optional lead-zero mask is enabled with the LEAD_ZERO_MASK_EN macro.
package bcd_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int MAX_VAL    = 9999;
  localparam logic [4*BCD_DIGITS-1:0] SAT_BCD = 16'h9999;

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef logic [4*BCD_DIGITS-1:0] bcd_word_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Define LEAD_ZERO_MASK_EN to add the registered lz_mask output.
module bin_to_bcd_seq #(
  parameter int BIN_W   = bcd_pkg::BIN_W,
  parameter int DIGITS  = bcd_pkg::BCD_DIGITS,
  parameter int MAX_VAL = bcd_pkg::MAX_VAL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                ovf
`ifdef LEAD_ZERO_MASK_EN
  ,
  output logic [DIGITS-1:0]   lz_mask
`endif
);

  import bcd_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [BCD_W-1:0] SAT_WORD = {DIGITS{4'h9}};

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [BCD_W-1:0] bcd_q, bcd_nx, bcd_fix, bcd_shift;
  logic [BIN_W-1:0] bin_q, bin_nx, bin_shift;
  logic             ovf_pend, ovf_pend_nx;
  logic [BCD_W-1:0] bcd_out_nx;
  logic             ovf_nx, done_nx;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_fix[4*g +: 4])
    );
  end

  // The top BCD bit falls off the end; it only carries data for out-of-range inputs, which saturate anyway.
  assign bcd_shift = BCD_W'({bcd_fix, bin_q[BIN_W-1]});
  assign bin_shift = {bin_q[BIN_W-2:0], 1'b0};
  assign busy      = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bcd_q    <= '0;
      bin_q    <= '0;
      ovf_pend <= 1'b0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bcd_q    <= bcd_nx;
      bin_q    <= bin_nx;
      ovf_pend <= ovf_pend_nx;
      bcd_out  <= bcd_out_nx;
      ovf      <= ovf_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bcd_nx      = bcd_q;
    bin_nx      = bin_q;
    ovf_pend_nx = ovf_pend;
    bcd_out_nx  = bcd_out;
    ovf_nx      = ovf;
    done_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          bin_nx      = bin_in;
          bcd_nx      = '0;
          cnt_nx      = '0;
          ovf_pend_nx = (bin_in > MAX_BIN);
          state_nx    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_nx = bcd_shift;
        bin_nx = bin_shift;
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          state_nx   = IDLE;
          done_nx    = 1'b1;
          bcd_out_nx = ovf_pend ? SAT_WORD : bcd_shift;
          ovf_nx     = ovf_pend;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef LEAD_ZERO_MASK_EN
  logic [DIGITS-1:0] lz_nx;
  logic              zero_run;

  // Walk down from the top digit; a digit is masked while every digit above it is also zero.
  always_comb begin
    lz_nx    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (bcd_out_nx[4*i +: 4] == 4'h0);
      lz_nx[i] = zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lz_mask <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if (done_nx) begin
      lz_mask <= lz_nx;
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq; lz_mask checks are built when LEAD_ZERO_MASK_EN is defined.
module tb_bin_to_bcd_seq;

  import bcd_pkg::*;

  localparam int LATENCY = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [BIN_W-1:0]  bin_in;
  logic              busy;
  logic              done;
  bcd_word_t         bcd_out;
  logic              ovf;
`ifdef LEAD_ZERO_MASK_EN
  logic [BCD_DIGITS-1:0] lz_mask;
`endif

  int nChecks = 0;
  int nFails  = 0;
  int edgeCount = 0;

  typedef struct {
    string            tag;
    logic [BIN_W-1:0] val;
    bcd_word_t        expBcd;
    logic             expOvf;
    logic [3:0]       expLz;
  } vec_t;

  vec_t vecs[$];

  bin_to_bcd_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
`ifdef LEAD_ZERO_MASK_EN
    ,
    .lz_mask (lz_mask)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge; mark is the edge count right after the accepting edge.
  task automatic applyStimulus(input logic [BIN_W-1:0] val, output int mark);
    @(negedge clk);
    start  = 1'b1;
    bin_in = val;
    @(negedge clk);
    start  = 1'b0;
    mark   = edgeCount;
  endtask

  task automatic waitDone(input string tag, input int mark);
    while (!done && (edgeCount - mark) < 40) @(negedge clk);
    checkOutput({tag, "_lat"}, edgeCount - mark, LATENCY);
    checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  task automatic runConversion(input vec_t v);
    int mark;
    applyStimulus(v.val, mark);
    checkOutput({v.tag, "_busy"}, busy, 1'b1);
    waitDone(v.tag, mark);
    checkOutput({v.tag, "_bcd"}, bcd_out, v.expBcd);
    checkOutput({v.tag, "_ovf"}, ovf, v.expOvf);
`ifdef LEAD_ZERO_MASK_EN
    checkOutput({v.tag, "_lz"}, lz_mask, v.expLz);
`endif
    @(negedge clk);
    checkOutput({v.tag, "_pulse"}, done, 1'b0);
    checkOutput({v.tag, "_hold"}, bcd_out, v.expBcd);
  endtask

  initial begin
    int mark;
    int doneSeen;

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_bcd", bcd_out, 16'h0000);
    checkOutput("rst_ovf", ovf, 1'b0);
`ifdef LEAD_ZERO_MASK_EN
    checkOutput("rst_lz", lz_mask, 4'b1110);
`endif
    rst_n = 1'b1;

    vecs.push_back('{"v0",     14'd0,     16'h0000, 1'b0, 4'b1110});
    vecs.push_back('{"v1234",  14'd1234,  16'h1234, 1'b0, 4'b0000});
    vecs.push_back('{"v9999",  14'd9999,  16'h9999, 1'b0, 4'b0000});
    vecs.push_back('{"v8272",  14'd8272,  16'h8272, 1'b0, 4'b0000});
    vecs.push_back('{"v10000", 14'd10000, 16'h9999, 1'b1, 4'b0000});
    vecs.push_back('{"v704",   14'd704,   16'h0704, 1'b0, 4'b1000});
    vecs.push_back('{"v16383", 14'd16383, 16'h9999, 1'b1, 4'b0000});
    vecs.push_back('{"v5",     14'd5,     16'h0005, 1'b0, 4'b1110});
    vecs.push_back('{"v9090",  14'd9090,  16'h9090, 1'b0, 4'b0000});
    foreach (vecs[i]) runConversion(vecs[i]);

    // A start (with a new operand) during a conversion must be ignored.
    applyStimulus(14'd7777, mark);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd1111;
    @(negedge clk);
    start  = 1'b0;
    bin_in = '0;
    checkOutput("ign_busy", busy, 1'b1);
    waitDone("ign", mark);
    checkOutput("ign_bcd", bcd_out, 16'h7777);

    // A start presented in the done cycle is accepted immediately.
    start  = 1'b1;
    bin_in = 14'd9119;
    @(negedge clk);
    start  = 1'b0;
    mark   = edgeCount;
    checkOutput("b2b_pulse", done, 1'b0);
    checkOutput("b2b_busy", busy, 1'b1);
    waitDone("b2b", mark);
    checkOutput("b2b_bcd", bcd_out, 16'h9119);
    checkOutput("b2b_ovf", ovf, 1'b0);

    // Reset in the middle of a conversion aborts it without a done pulse.
    applyStimulus(14'd5000, mark);
    while ((edgeCount - mark) < 6) @(negedge clk);
    checkOutput("abort_hold", bcd_out, 16'h9119);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_bcd", bcd_out, 16'h0000);
    checkOutput("abort_done", done, 1'b0);
`ifdef LEAD_ZERO_MASK_EN
    checkOutput("abort_lz", lz_mask, 4'b1110);
`endif
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort_nodone", doneSeen, 0);
    runConversion('{"post_rst", 14'd4321, 16'h4321, 1'b0, 4'b0000});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
